// File: rtl/uart_frame_assembler_pkg.sv
// ============================================================================
// Module      : uart_frame_assembler_pkg
// Description : Shared state encoding and default frame parameters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package uart_frame_assembler_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2,
        READY   = 2'd3
    } state_t;

    localparam int         DEF_FRAME_BYTES    = 784;
    localparam int         DEF_ADDR_WIDTH     = 10;
    localparam logic [7:0] DEF_SYNC_BYTE      = 8'hAA;
    localparam int         DEF_TIMEOUT_CYCLES = 100000;

endpackage

`default_nettype wire

// File: rtl/uart_frame_assembler_ram.sv
// ============================================================================
// Module      : frame_buffer_ram
// Description : Single write port, registered read port pixel buffer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module frame_buffer_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [7:0]            wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [7:0]            rd_data
);

    logic [7:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the output register is reset; array contents are left untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= 8'd0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_frame_assembler.sv
// ============================================================================
// Module      : uart_frame_assembler
// Description : Assembles sync + pixel bytes + checksum into a held frame.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module uart_frame_assembler
    import uart_frame_assembler_pkg::*;
#(
    parameter int         FRAME_BYTES    = DEF_FRAME_BYTES,
    parameter int         ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [7:0]            rd_data,
    output logic                  frame_ready,
    input  logic                  frame_ack,
    output logic                  busy,
    output logic                  checksum_error,
    output logic                  timeout_error,
    output logic                  overrun
);

    localparam int               CNT_W     = $clog2(FRAME_BYTES + 1);
    localparam int               TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] byte_count, byte_count_next;
    logic [7:0]       sum, sum_next;
    logic [TMR_W-1:0] timer, timer_next;
    logic             wr_en;
    logic             cksum_err_next, timeout_next, overrun_next;

    always_comb begin
        state_next      = state;
        byte_count_next = byte_count;
        sum_next        = sum;
        timer_next      = timer;
        wr_en           = 1'b0;
        cksum_err_next  = 1'b0;
        timeout_next    = 1'b0;
        overrun_next    = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_next      = COLLECT;
                    byte_count_next = '0;
                    sum_next        = '0;
                    timer_next      = '0;
                end
            end
            COLLECT: begin
                if (rx_valid) begin
                    wr_en           = 1'b1;
                    sum_next        = sum + rx_data;
                    byte_count_next = byte_count + 1'b1;
                    timer_next      = '0;
                    if (byte_count == LAST_BYTE) begin
                        state_next = CHECK;
                    end
                end else if (timer == TMR_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            CHECK: begin
                if (rx_valid) begin
                    timer_next = '0;
                    if (rx_data == sum) begin
                        state_next = READY;
                    end else begin
                        cksum_err_next = 1'b1;
                        state_next     = IDLE;
                    end
                end else if (timer == TMR_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            READY: begin
                // A byte arriving with the ack is still dropped, never treated as sync.
                overrun_next = rx_valid;
                if (frame_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            byte_count     <= '0;
            sum            <= '0;
            timer          <= '0;
            frame_ready    <= 1'b0;
            busy           <= 1'b0;
            checksum_error <= 1'b0;
            timeout_error  <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            state          <= state_next;
            byte_count     <= byte_count_next;
            sum            <= sum_next;
            timer          <= timer_next;
            frame_ready    <= (state_next == READY);
            busy           <= (state_next == COLLECT) || (state_next == CHECK);
            checksum_error <= cksum_err_next;
            timeout_error  <= timeout_next;
            overrun        <= overrun_next;
        end
    end

    frame_buffer_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_frame_buffer_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (ADDR_WIDTH'(byte_count)),
        .wr_data (rx_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

`default_nettype wire
